// File: rtl/pipe_reduce_tree_if.sv
// Sample bus into and result bus out of pipe_reduce_tree; inflight exists only with PIPE_REDUCE_INFLIGHT_EN.
interface pipe_reduce_tree_if #(
    parameter int WIDTH = 4
`ifdef PIPE_REDUCE_INFLIGHT_EN
    , parameter int LAT = $clog2(WIDTH)
`endif
);
    logic             en;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out;
    logic             out_valid;
    logic [1:0]       out_mode;
`ifdef PIPE_REDUCE_INFLIGHT_EN
    logic [$clog2(LAT+1)-1:0] inflight;

    modport master (output en, in_valid, in_data, in_mode,
                    input  out, out_valid, out_mode, inflight);
    modport slave  (input  en, in_valid, in_data, in_mode,
                    output out, out_valid, out_mode, inflight);
`else
    modport master (output en, in_valid, in_data, in_mode,
                    input  out, out_valid, out_mode);
    modport slave  (input  en, in_valid, in_data, in_mode,
                    output out, out_valid, out_mode);
`endif
endinterface

// File: rtl/pipe_reduce_tree.sv
// Balanced binary AND/OR/XOR/NAND reduction of WIDTH bits; PIPE_REDUCE_INFLIGHT_EN adds an inflight count.
// Latency LAT = $clog2(WIDTH)*LVL_DELAY cycles, one sample per cycle.
// No ready: en=0 freezes every stage and samples offered meanwhile are dropped.
module pipe_reduce_tree #(
    parameter int WIDTH     = 4,
    parameter int LVL_DELAY = 1
) (
    input  logic              clock,
    input  logic              reset,
    pipe_reduce_tree_if.slave bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int TAP_W  = 2 * WIDTH - 1;

    // Level k's output occupies tap_dat[2*WIDTH-2*(WIDTH>>k) +: WIDTH>>k]; level 0 is in_data.
    logic [TAP_W-1:0]     tap_dat;
    logic [LEVELS:0]      tap_vld;
    logic [LEVELS:0][1:0] tap_mode;

    assign tap_dat[WIDTH-1:0] = bus.in_data;
    assign tap_vld[0]         = bus.in_valid;
    assign tap_mode[0]        = bus.in_mode;

`ifdef PIPE_REDUCE_INFLIGHT_EN
    localparam int LAT   = LEVELS * LVL_DELAY;
    localparam int CNT_W = $clog2(LAT + 1);

    logic [LAT-1:0] nxt_vld;
`endif

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        localparam int W_IN   = WIDTH >> (k - 1);
        localparam int W      = WIDTH >> k;
        localparam int OFF_IN = 2 * WIDTH - 2 * W_IN;
        localparam int OFF    = 2 * WIDTH - 2 * W;

        logic [W_IN-1:0]              src_dat;
        logic                         src_vld;
        logic [1:0]                   src_mode;
        logic [W-1:0]                 red;
        logic [LVL_DELAY-1:0]         vld_d, vld_q;
        logic [LVL_DELAY-1:0][1:0]    mode_d, mode_q;
        logic [LVL_DELAY-1:0][W-1:0]  dat_d, dat_q;

        assign src_dat  = tap_dat[OFF_IN +: W_IN];
        assign src_vld  = tap_vld[k-1];
        assign src_mode = tap_mode[k-1];

        // NAND is an AND tree with the root inverted, so only the last level looks at mode 11.
        always_comb begin
            red = '0;
            for (int i = 0; i < W; i++) begin
                case (src_mode)
                    2'b01:   red[i] = src_dat[2*i] | src_dat[2*i+1];
                    2'b10:   red[i] = src_dat[2*i] ^ src_dat[2*i+1];
                    default: red[i] = src_dat[2*i] & src_dat[2*i+1];
                endcase
            end
            if (k == LEVELS && src_mode == 2'b11) begin
                red = ~red;
            end
        end

        always_comb begin
            vld_d  = vld_q;
            mode_d = mode_q;
            dat_d  = dat_q;
            if (bus.en) begin
                vld_d[0] = src_vld;
                if (src_vld) begin
                    mode_d[0] = src_mode;
                    dat_d[0]  = red;
                end
                for (int s = 1; s < LVL_DELAY; s++) begin
                    vld_d[s] = vld_q[s-1];
                    if (vld_q[s-1]) begin
                        mode_d[s] = mode_q[s-1];
                        dat_d[s]  = dat_q[s-1];
                    end
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                vld_q  <= '0;
                mode_q <= '0;
                dat_q  <= '0;
            end else begin
                vld_q  <= vld_d;
                mode_q <= mode_d;
                dat_q  <= dat_d;
            end
        end

        assign tap_vld[k]        = vld_q[LVL_DELAY-1];
        assign tap_mode[k]       = mode_q[LVL_DELAY-1];
        assign tap_dat[OFF +: W] = dat_q[LVL_DELAY-1];
`ifdef PIPE_REDUCE_INFLIGHT_EN
        assign nxt_vld[(k-1)*LVL_DELAY +: LVL_DELAY] = vld_d;
`endif
    end

    assign bus.out       = tap_dat[TAP_W-1];
    assign bus.out_valid = tap_vld[LEVELS];
    assign bus.out_mode  = tap_mode[LEVELS];

`ifdef PIPE_REDUCE_INFLIGHT_EN
    logic [CNT_W-1:0] inflight_d, inflight_q;

    // Counting next-state valids keeps the count aligned with the stage registers it describes.
    always_comb begin
        inflight_d = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_d = inflight_d + CNT_W'(nxt_vld[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign bus.inflight = inflight_q;
`endif
endmodule

// File: tb/tb_pipe_reduce_tree.sv
// Directed bench: dut_a is WIDTH=4/LVL_DELAY=2 (LAT 4), dut_b is WIDTH=8/LVL_DELAY=1 (LAT 3).
module tb_pipe_reduce_tree;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

`ifdef PIPE_REDUCE_INFLIGHT_EN
    pipe_reduce_tree_if #(.WIDTH(4), .LAT(4)) bus_a ();
    pipe_reduce_tree_if #(.WIDTH(8), .LAT(3)) bus_b ();
`else
    pipe_reduce_tree_if #(.WIDTH(4)) bus_a ();
    pipe_reduce_tree_if #(.WIDTH(8)) bus_b ();
`endif

    pipe_reduce_tree #(.WIDTH(4), .LVL_DELAY(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    pipe_reduce_tree #(.WIDTH(8), .LVL_DELAY(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic v, input logic o, input logic [1:0] m);
        chk({tag, ".a.vld"},  8'(bus_a.out_valid), 8'(v));
        chk({tag, ".a.out"},  8'(bus_a.out),       8'(o));
        chk({tag, ".a.mode"}, 8'(bus_a.out_mode),  8'(m));
    endtask

    task automatic expect_b(input string tag, input logic v, input logic o, input logic [1:0] m);
        chk({tag, ".b.vld"},  8'(bus_b.out_valid), 8'(v));
        chk({tag, ".b.out"},  8'(bus_b.out),       8'(o));
        chk({tag, ".b.mode"}, 8'(bus_b.out_mode),  8'(m));
    endtask

    // Drive, then sample 1 ns after the edge that consumed the drive.
    task automatic step_a(input logic en, input logic v, input logic [3:0] d, input logic [1:0] m);
        bus_a.en       = en;
        bus_a.in_valid = v;
        bus_a.in_data  = d;
        bus_a.in_mode  = m;
        @(posedge clock);
        #1;
    endtask

    task automatic step_b(input logic en, input logic v, input logic [7:0] d, input logic [1:0] m);
        bus_b.en       = en;
        bus_b.in_valid = v;
        bus_b.in_data  = d;
        bus_b.in_mode  = m;
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus_a.en = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_mode = '0;
        bus_b.en = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_mode = '0;

        #2;
        expect_a("reset", 1'b0, 1'b0, 2'b00);
        expect_b("reset", 1'b0, 1'b0, 2'b00);
`ifdef PIPE_REDUCE_INFLIGHT_EN
        chk("reset.inflight", 8'(bus_a.inflight), 8'd0);
`endif
        #10 reset = 1'b0;
        @(posedge clock);
        #1;

        // Single AND sample, then a single zero bit.
        step_a(1, 1, 4'b1111, 2'b00); expect_a("and1.e1", 0, 0, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("and1.e2", 0, 0, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("and1.e3", 0, 0, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("and1.e4", 1, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("and1.e5", 0, 1, 2'b00);
        step_a(1, 1, 4'b1110, 2'b00); expect_a("and0.e1", 0, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("and0.e2", 0, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("and0.e3", 0, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("and0.e4", 1, 0, 2'b00);

        // Back-to-back modes: AND 1111=1, OR 0001=1, XOR 0011=0, NAND 1111=0.
        step_a(1, 1, 4'b1111, 2'b00); expect_a("b2b.e1", 0, 0, 2'b00);
        step_a(1, 1, 4'b0001, 2'b01); expect_a("b2b.e2", 0, 0, 2'b00);
        step_a(1, 1, 4'b0011, 2'b10); expect_a("b2b.e3", 0, 0, 2'b00);
        step_a(1, 1, 4'b1111, 2'b11); expect_a("b2b.and",  1, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("b2b.or",   1, 1, 2'b01);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("b2b.xor",  1, 0, 2'b10);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("b2b.nand", 1, 0, 2'b11);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("b2b.idle", 0, 0, 2'b11);

        // Stall edges 2-4; samples offered while stalled must be dropped.
        step_a(1, 1, 4'b1111, 2'b00); expect_a("stall.e1", 0, 0, 2'b11);
        step_a(0, 1, 4'b0000, 2'b01); expect_a("stall.e2", 0, 0, 2'b11);
        step_a(0, 1, 4'b0000, 2'b01); expect_a("stall.e3", 0, 0, 2'b11);
        step_a(0, 1, 4'b0000, 2'b01); expect_a("stall.e4", 0, 0, 2'b11);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("stall.e5", 0, 0, 2'b11);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("stall.e6", 0, 0, 2'b11);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("stall.e7", 1, 1, 2'b00);
        step_a(0, 0, 4'b0000, 2'b00); expect_a("stall.hold1", 1, 1, 2'b00);
        step_a(0, 0, 4'b0000, 2'b00); expect_a("stall.hold2", 1, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("stall.drop", 0, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("stall.drain", 0, 1, 2'b00);

        // Three samples in flight, then async reset while en=0.
        step_a(1, 1, 4'b1111, 2'b00); expect_a("flush.e1", 0, 1, 2'b00);
        step_a(1, 1, 4'b1111, 2'b01); expect_a("flush.e2", 0, 1, 2'b00);
        step_a(1, 1, 4'b1111, 2'b10); expect_a("flush.e3", 0, 1, 2'b00);
        bus_a.en = 1'b0;
        bus_a.in_valid = 1'b0;
        #3 reset = 1'b1;
        #1;
        expect_a("flush.async", 0, 0, 2'b00);
        #10 reset = 1'b0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 5; i++) begin
            step_a(1, 0, 4'b0000, 2'b00); expect_a("flush.quiet", 0, 0, 2'b00);
        end
        step_a(1, 1, 4'b1111, 2'b00); expect_a("post.e1", 0, 0, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("post.e2", 0, 0, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("post.e3", 0, 0, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("post.e4", 1, 1, 2'b00);
        step_a(1, 0, 4'b0000, 2'b00); expect_a("post.e5", 0, 1, 2'b00);

        // WIDTH=8 OR tree: 00 then bubble then 80.
        step_b(1, 1, 8'h00, 2'b01); expect_b("or8.e1", 0, 0, 2'b00);
        step_b(1, 0, 8'h00, 2'b00); expect_b("or8.e2", 0, 0, 2'b00);
        step_b(1, 1, 8'h80, 2'b01); expect_b("or8.e3", 1, 0, 2'b01);
        step_b(1, 0, 8'h00, 2'b00); expect_b("or8.e4", 0, 0, 2'b01);
        step_b(1, 0, 8'h00, 2'b00); expect_b("or8.e5", 1, 1, 2'b01);
        step_b(1, 0, 8'h00, 2'b00); expect_b("or8.e6", 0, 1, 2'b01);

`ifdef PIPE_REDUCE_INFLIGHT_EN
        step_a(1, 1, 4'b1111, 2'b00); chk("infl.1", 8'(bus_a.inflight), 8'd1);
        step_a(1, 1, 4'b1111, 2'b00); chk("infl.2", 8'(bus_a.inflight), 8'd2);
        step_a(1, 1, 4'b1111, 2'b00); chk("infl.3", 8'(bus_a.inflight), 8'd3);
        step_a(1, 1, 4'b1111, 2'b00); chk("infl.4", 8'(bus_a.inflight), 8'd4);
        step_a(0, 0, 4'b0000, 2'b00); chk("infl.hold", 8'(bus_a.inflight), 8'd4);
        step_a(1, 0, 4'b0000, 2'b00); chk("infl.d3", 8'(bus_a.inflight), 8'd3);
        step_a(1, 0, 4'b0000, 2'b00); chk("infl.d2", 8'(bus_a.inflight), 8'd2);
        step_a(1, 0, 4'b0000, 2'b00); chk("infl.d1", 8'(bus_a.inflight), 8'd1);
        step_a(1, 0, 4'b0000, 2'b00); chk("infl.d0", 8'(bus_a.inflight), 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
